// File: rtl/dpll_nco.sv
// -----------------------------------------------------------------------------
// dpll_nco -- numerically controlled oscillator for the data-separator DPLL.
//
// A phase accumulator advances by freq_word on every enabled clock. Its MSB
// is the recovered bit clock: low for the first half of a bit cell and high
// for the second half. A registered one-cycle strobe marks the mid-bit
// sampling instant, which is the MSB 0->1 crossing. The loop filter trims
// phase through a signed adjustment. The adjustment is sign-extended and
// shifted left by ADJ_SHIFT, and it is applied even while the accumulator
// is otherwise held.
//
// Parameters
//   ACC_WIDTH  phase accumulator / freq_word width (> ADJ_WIDTH)
//   ADJ_WIDTH  phase_adj width, signed two's complement
//   ADJ_SHIFT  left shift applied to the sign-extended phase_adj
//
// Ports
//   clk              in   system clock
//   reset_n          in   asynchronous active-low reset
//   enable           in   1 = accumulate freq_word, 0 = hold phase
//   freq_word        in   per-clock phase increment
//   phase_adj        in   signed phase correction
//   phase_adj_valid  in   apply phase_adj this cycle
//   bit_clk          out  recovered bit clock (accumulator MSB)
//   phase_accum      out  registered accumulator value
//   sample_point     out  one-cycle mid-bit strobe, coincident with bit_clk rise
//   bit_boundary     out  (only with NCO_BIT_BOUNDARY_EN defined) one-cycle
//                         pulse when the enabled accumulator wraps, which
//                         marks the start of a bit cell
//
// Configuration macro: NCO_BIT_BOUNDARY_EN (adds the bit_boundary output).
// -----------------------------------------------------------------------------
module dpll_nco #(
  parameter int ACC_WIDTH = 32,
  parameter int ADJ_WIDTH = 16,
  parameter int ADJ_SHIFT = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [ACC_WIDTH-1:0] freq_word,
  input  logic [ADJ_WIDTH-1:0] phase_adj,
  input  logic                 phase_adj_valid,
  output logic                 bit_clk,
  output logic [ACC_WIDTH-1:0] phase_accum,
  output logic                 sample_point
`ifdef NCO_BIT_BOUNDARY_EN
  ,
  output logic                 bit_boundary
`endif
);

  localparam int MSB = ACC_WIDTH - 1;

  logic [ACC_WIDTH-1:0] phase_accum_q, phase_accum_d;
  logic                 sample_point_q, sample_point_d;
  logic [ACC_WIDTH-1:0] freq_inc;
  logic [ACC_WIDTH-1:0] adj_ext;
  logic [ACC_WIDTH-1:0] adj_inc;
  logic [ACC_WIDTH-1:0] inc;

`ifdef NCO_BIT_BOUNDARY_EN
  logic                 bit_boundary_q, bit_boundary_d;
`endif

  // NOTE: every signal written here gets an unconditional value first, so
  // no path through the block leaves a variable unassigned (no latches).
  always_comb begin
    freq_inc       = '0;
    adj_inc        = '0;
    adj_ext        = {{(ACC_WIDTH-ADJ_WIDTH){phase_adj[ADJ_WIDTH-1]}}, phase_adj};

    if (enable)          freq_inc = freq_word;
    // The shift pushes the correction into the upper phase bits.
    // 0x1000 << 16 = 1/16 of a bit cell.
    if (phase_adj_valid) adj_inc  = adj_ext << ADJ_SHIFT;

    // A negative adjustment is two's complement, so one modular add
    // handles both signs. The result wraps silently.
    inc            = freq_inc + adj_inc;
    phase_accum_d  = phase_accum_q + inc;

    // Mid-bit sample point is the MSB 0->1 crossing. Crossings caused only
    // by an adjustment while disabled must not strobe, so the strobe is
    // qualified with enable.
    sample_point_d = enable & ~phase_accum_q[MSB] & phase_accum_d[MSB];

`ifdef NCO_BIT_BOUNDARY_EN
    // A modular add carried out exactly when the result is below the old
    // value. A non-negative increment then means a genuine forward wrap
    // (MSB 1->0). A negative adjustment does not count as a wrap.
    bit_boundary_d = enable & ~inc[MSB] & (phase_accum_d < phase_accum_q);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then sample their inputs on the same edge, regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_accum_q  <= '0;
      sample_point_q <= 1'b0;
    end else begin
      phase_accum_q  <= phase_accum_d;
      sample_point_q <= sample_point_d;
    end
  end

`ifdef NCO_BIT_BOUNDARY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bit_boundary_q <= 1'b0;
    else          bit_boundary_q <= bit_boundary_d;
  end

  assign bit_boundary = bit_boundary_q;
`endif

  // bit_clk comes straight from the accumulator flop. It therefore clears
  // together with the async reset and lines up with the registered strobe.
  assign bit_clk      = phase_accum_q[MSB];
  assign phase_accum  = phase_accum_q;
  assign sample_point = sample_point_q;

endmodule

// File: tb/tb_dpll_nco.sv
// -----------------------------------------------------------------------------
// tb_dpll_nco -- directed self-checking bench for dpll_nco (default build).
// Inputs change 1 time unit after the rising edge. Outputs are compared at
// the same point, well clear of the next active edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dpll_nco;

  localparam logic [31:0] FW_250K = 32'h0051_EB85;
  localparam logic [31:0] FW_300K = 32'h0062_4DD3;
  localparam logic [31:0] FW_500K = 32'h00A3_D70A;
  localparam logic [31:0] FW_1M   = 32'h0147_AE14;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] freq_word = '0;
  logic [15:0] phase_adj = '0;
  logic        phase_adj_valid = 1'b0;
  logic        bit_clk;
  logic [31:0] phase_accum;
  logic        sample_point;

  int n_checks = 0;
  int n_fail   = 0;

  dpll_nco #(.ACC_WIDTH(32), .ADJ_WIDTH(16), .ADJ_SHIFT(16)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .enable          (enable),
    .freq_word       (freq_word),
    .phase_adj       (phase_adj),
    .phase_adj_valid (phase_adj_valid),
    .bit_clk         (bit_clk),
    .phase_accum     (phase_accum),
    .sample_point    (sample_point)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] fw,
                       input logic [15:0] adj, input logic adj_v);
    enable          = en;
    freq_word       = fw;
    phase_adj       = adj;
    phase_adj_valid = adj_v;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] acc, input logic sp);
    check({tag, "_acc"}, 64'(phase_accum), 64'(acc));
    check({tag, "_bclk"}, 64'(bit_clk), 64'(acc[31]));
    check({tag, "_sp"}, 64'(sample_point), 64'(sp));
  endtask

  // Runs n clocks at freq word fw and counts bit_clk edges and strobes. It
  // also counts strobes that do not coincide with a bit_clk rise.
  task automatic measure(input logic [31:0] fw, input int n,
                         output int edges, output int sps, output int misalign);
    logic prev;
    edges = 0; sps = 0; misalign = 0;
    drive(1'b1, fw, 16'h0000, 1'b0);
    prev = bit_clk;
    for (int i = 0; i < n; i++) begin
      tick();
      if (bit_clk !== prev) edges++;
      if (sample_point === 1'b1) sps++;
      if (sample_point !== (bit_clk & ~prev)) misalign++;
      prev = bit_clk;
    end
  endtask

  task automatic rate_test(input string tag, input logic [31:0] fw, input int n,
                           input int e_lo, input int e_hi, input int s_lo, input int s_hi);
    int edges, sps, misalign;
    measure(fw, n, edges, sps, misalign);
    check({tag, "_edges_in_range"}, 64'(edges >= e_lo && edges <= e_hi), 64'd1);
    check({tag, "_strobes_in_range"}, 64'(sps >= s_lo && sps <= s_hi), 64'd1);
    check({tag, "_strobe_alignment_errors"}, 64'(misalign), 64'd0);
  endtask

  initial begin
    bit found;

    // Async reset: outputs must clear before any clock edge.
    #1 reset_n = 1'b0;
    #1;
    expect_state("reset_async", 32'h0, 1'b0);
    tick(); tick();
    reset_n = 1'b1;
    tick(); tick();
    expect_state("idle_after_reset", 32'h0, 1'b0);

    // Quarter-cell increments give exact, hand-checkable phases.
    drive(1'b1, 32'h4000_0000, 16'h0000, 1'b0);
    tick(); expect_state("q1", 32'h4000_0000, 1'b0);
    tick(); expect_state("q2_mid_bit", 32'h8000_0000, 1'b1);
    tick(); expect_state("q3", 32'hC000_0000, 1'b0);
    tick(); expect_state("q4_wrap", 32'h0000_0000, 1'b0);
    tick(); expect_state("q5", 32'h4000_0000, 1'b0);

    // Adjustment while disabled: +1/16 then -1/16 returns to P.
    drive(1'b0, 32'h4000_0000, 16'h1000, 1'b1);
    tick(); expect_state("adj_plus", 32'h5000_0000, 1'b0);
    drive(1'b0, 32'h4000_0000, 16'hF000, 1'b1);
    tick(); expect_state("adj_minus", 32'h4000_0000, 1'b0);
    // An adjustment that crosses the MSB while disabled must not strobe.
    drive(1'b0, 32'h4000_0000, 16'h4000, 1'b1);
    tick(); expect_state("adj_cross_no_strobe", 32'h8000_0000, 1'b0);
    drive(1'b0, 32'h4000_0000, 16'hC000, 1'b1);
    tick(); expect_state("adj_back", 32'h4000_0000, 1'b0);
    drive(1'b0, 32'h4000_0000, 16'h4000, 1'b0);
    tick(); expect_state("adj_invalid_ignored", 32'h4000_0000, 1'b0);

    // Adjustment combined with frequency, both signs.
    drive(1'b1, 32'h1000_0000, 16'h1000, 1'b1);
    tick(); expect_state("fw_plus_adj", 32'h6000_0000, 1'b0);
    drive(1'b1, 32'h1000_0000, 16'hE000, 1'b1);
    tick(); expect_state("fw_minus_adj", 32'h5000_0000, 1'b0);

    // Strobe, then hold for two cycles, then resume.
    drive(1'b1, 32'h3000_0000, 16'h0000, 1'b0);
    tick(); expect_state("pre_hold_strobe", 32'h8000_0000, 1'b1);
    drive(1'b0, 32'h3000_0000, 16'h0000, 1'b0);
    tick(); expect_state("hold1", 32'h8000_0000, 1'b0);
    tick(); expect_state("hold2", 32'h8000_0000, 1'b0);
    drive(1'b1, 32'h3000_0000, 16'h0000, 1'b0);
    tick(); expect_state("resume", 32'hB000_0000, 1'b0);
    drive(1'b1, 32'h6000_0000, 16'h0000, 1'b0);
    tick(); expect_state("modular_wrap", 32'h1000_0000, 1'b0);

    // Standard data rates. 20000 clk corresponds to 100 us at 200 MHz.
    rate_test("rate_500k", FW_500K, 20000, 90, 110, 45, 55);
    rate_test("rate_1m",   FW_1M,   20000, 180, 220, 90, 110);
    rate_test("rate_250k", FW_250K, 10000, 22, 28, 11, 14);
    rate_test("rate_300k", FW_300K, 10000, 27, 33, 13, 17);

    // Mid-run reset while bit_clk is high. Clearing must happen before the
    // next edge.
    drive(1'b1, FW_1M, 16'h0000, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick();
      if (bit_clk === 1'b1) found = 1'b1;
    end
    check("midrun_bit_clk_high_seen", 64'(found), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    expect_state("midrun_reset_async", 32'h0, 1'b0);
    tick();
    expect_state("midrun_reset_held", 32'h0, 1'b0);
    reset_n = 1'b1;
    drive(1'b1, 32'h4000_0000, 16'h0000, 1'b0);
    tick(); expect_state("post_reset_run", 32'h4000_0000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
